// File: rtl/divider_result_buffer.sv
// Result FIFO behind the divider: first-word-fall-through ready/valid output plus
// credit tracking of operations in flight so no divider result is ever dropped.
module divider_result_buffer #(
  parameter int DATA_BITDEPTH = 16,
  parameter int ADDR_BITDEPTH = 4
) (
  input  logic                     i_rstn,
  input  logic                     i_sclk,
  input  logic                     i_clear,
  input  logic                     i_issue,
  output logic                     o_issue_ok,
  input  logic                     i_div_valid,
  input  logic [DATA_BITDEPTH-1:0] i_quotient,
  input  logic [DATA_BITDEPTH-1:0] i_remainder,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_BITDEPTH-1:0] o_quotient,
  output logic [DATA_BITDEPTH-1:0] o_remainder,
  output logic [ADDR_BITDEPTH:0]   o_count,
  output logic [1:0]               o_error
);

  localparam int DEPTH = 2 ** ADDR_BITDEPTH;
  localparam logic [ADDR_BITDEPTH:0] FULL_CNT = DEPTH[ADDR_BITDEPTH:0];

  typedef struct packed {
    logic [DATA_BITDEPTH-1:0] quo;
    logic [DATA_BITDEPTH-1:0] rem;
  } entry_t;

  entry_t                   mem [DEPTH];
  entry_t                   head;
  logic [ADDR_BITDEPTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITDEPTH:0]   occ, inflight;
  logic [ADDR_BITDEPTH+1:0] credit_sum;
  logic [1:0]               err;
  logic                     full, push, pop, ovf, unexp, infl_inc, infl_dec;

  assign full     = (occ == FULL_CNT);
  assign pop      = o_valid && i_ready && !i_clear;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = i_div_valid && !i_clear && (!full || pop);
  assign ovf      = i_div_valid && full && !pop;
  assign unexp    = i_div_valid && (inflight == '0) && !i_issue;
  assign infl_dec = i_div_valid && (inflight != '0);
  // Saturate rather than wrap if issue keeps ignoring credit; overflow is flagged anyway.
  assign infl_inc = i_issue && (inflight != '1);

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inflight <= '0;
      err      <= '0;
    end else if (i_clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inflight <= '0;
      err      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_BITDEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_BITDEPTH'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (ADDR_BITDEPTH+1)'(1);
        2'b01:   occ <= occ - (ADDR_BITDEPTH+1)'(1);
        default: occ <= occ;
      endcase
      if (i_issue && !infl_dec) begin
        if (infl_inc) inflight <= inflight + (ADDR_BITDEPTH+1)'(1);
      end else if (!i_issue && infl_dec) begin
        inflight <= inflight - (ADDR_BITDEPTH+1)'(1);
      end
      err <= err | {unexp, ovf};
    end
  end

  always_ff @(posedge i_sclk) begin
    if (push) mem[wr_ptr] <= '{quo: i_quotient, rem: i_remainder};
  end

  assign head        = mem[rd_ptr];
  assign o_valid     = (occ != '0);
  assign o_quotient  = o_valid ? head.quo : '0;
  assign o_remainder = o_valid ? head.rem : '0;
  assign o_count     = occ;
  assign o_error     = err;
  assign credit_sum  = {1'b0, occ} + {1'b0, inflight};
  assign o_issue_ok  = (credit_sum < {1'b0, FULL_CNT});

endmodule

// File: tb/tb_divider_result_buffer.sv
// Bench for divider_result_buffer: directed boundary cases plus a randomized run,
// all checked against a queue-based model of the FIFO and credit rules.
module tb_divider_result_buffer;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          i_rstn, i_sclk, i_clear, i_issue, i_div_valid, i_ready;
  logic [DW-1:0] i_quotient, i_remainder, o_quotient, o_remainder;
  logic          o_issue_ok, o_valid;
  logic [AW:0]   o_count;
  logic [1:0]    o_error;

  divider_result_buffer #(.DATA_BITDEPTH(DW), .ADDR_BITDEPTH(AW)) dut (
    .i_rstn(i_rstn), .i_sclk(i_sclk), .i_clear(i_clear), .i_issue(i_issue),
    .o_issue_ok(o_issue_ok), .i_div_valid(i_div_valid), .i_quotient(i_quotient),
    .i_remainder(i_remainder), .o_valid(o_valid), .i_ready(i_ready),
    .o_quotient(o_quotient), .o_remainder(o_remainder), .o_count(o_count),
    .o_error(o_error)
  );

  initial i_sclk = 1'b0;
  always #5 i_sclk = ~i_sclk;

  typedef struct {logic [DW-1:0] q; logic [DW-1:0] r;} res_t;
  typedef struct {int due; logic [DW-1:0] q; logic [DW-1:0] r;} pend_t;

  res_t     mq[$];
  int       m_infl;
  bit [1:0] m_err;
  int       n_chk, n_pass, dut_pops;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_all();
    chk("valid", 32'(o_valid), 32'(mq.size() != 0));
    chk("count", 32'(o_count), 32'(mq.size()));
    chk("issue_ok", 32'(o_issue_ok), 32'((mq.size() + m_infl) < DEPTH));
    chk("error", 32'(o_error), 32'(m_err));
    chk("quo", 32'(o_quotient), mq.size() != 0 ? 32'(mq[0].q) : 32'd0);
    chk("rem", 32'(o_remainder), mq.size() != 0 ? 32'(mq[0].r) : 32'd0);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input bit clr, input bit iss, input bit dv,
                     input logic [DW-1:0] qq, input logic [DW-1:0] rr, input bit rdy);
    bit pop, full;
    i_clear = clr; i_issue = iss; i_div_valid = dv;
    i_quotient = qq; i_remainder = rr; i_ready = rdy;
    if (o_valid && rdy && !clr) dut_pops++;
    pop  = (mq.size() > 0) && rdy;
    full = (mq.size() == DEPTH);
    @(posedge i_sclk);
    if (clr) begin
      mq.delete(); m_infl = 0; m_err = 2'b00;
    end else begin
      if (dv && m_infl == 0 && !iss) m_err[1] = 1'b1;
      if (pop) void'(mq.pop_front());
      if (dv) begin
        if (full && !pop) m_err[0] = 1'b1;
        else mq.push_back('{q: qq, r: rr});
      end
      if (iss && !(dv && m_infl > 0)) m_infl++;
      else if (!iss && dv && m_infl > 0) m_infl--;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, rdy);
  endtask

  task automatic ret(input logic [DW-1:0] qq, input logic [DW-1:0] rr, input bit rdy);
    cyc(1'b0, 1'b0, 1'b1, qq, rr, rdy);
  endtask

  logic [DW-1:0] eq[4];
  logic [DW-1:0] er[4];
  pend_t pend[$];

  initial begin
    n_chk = 0; n_pass = 0; dut_pops = 0;
    mq.delete(); m_infl = 0; m_err = 2'b00;
    i_rstn = 1'b0; i_clear = 1'b0; i_issue = 1'b0; i_div_valid = 1'b0;
    i_quotient = '0; i_remainder = '0; i_ready = 1'b0;
    repeat (3) @(posedge i_sclk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_issue_ok", 32'(o_issue_ok), 32'd1);
    chk("rst_quo", 32'(o_quotient), 32'd0);
    chk("rst_err", 32'(o_error), 32'd0);
    @(negedge i_sclk);
    i_rstn = 1'b1;
    idle(1'b0);

    // Four issues exhaust credit; results held back, then drained in order.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("issue_ok_after4", 32'(o_issue_ok), 32'd0);
    eq = '{16'd14, 16'd65535, 16'd30, 16'd0};
    er = '{16'd2, 16'd0, 16'd10, 16'd9};
    ret(16'd100 / 16'd7, 16'd100 % 16'd7, 1'b0);
    ret(16'd65535 / 16'd1, 16'd65535 % 16'd1, 1'b0);
    ret(16'd1000 / 16'd33, 16'd1000 % 16'd33, 1'b0);
    ret(16'd9 / 16'd10, 16'd9 % 16'd10, 1'b0);
    chk("full_count", 32'(o_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_quo", 32'(o_quotient), 32'(eq[i]));
      chk("drain_rem", 32'(o_remainder), 32'(er[i]));
      idle(1'b1);
    end
    chk("drained_count", 32'(o_count), 32'd0);
    chk("drained_issue_ok", 32'(o_issue_ok), 32'd1);

    // Full FIFO with simultaneous push and pop: accepted, no error.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) ret(16'(i + 40), 16'(i), 1'b0);
    ret(16'd15, 16'd2, 1'b1);
    chk("pp_count", 32'(o_count), 32'd4);
    chk("pp_err", 32'(o_error), 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("pp_last_quo", 32'(o_quotient), 32'd15);
    idle(1'b1);

    // Overflow: fifth result with no pop is dropped, stored entries intact.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 1; i <= 5; i++) ret(16'(i), 16'(i + 100), 1'b0);
    chk("ovf_err", 32'(o_error), 32'd1);
    chk("ovf_count", 32'(o_count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_quo", 32'(o_quotient), 32'(i));
      chk("ovf_rem", 32'(o_remainder), 32'(i + 100));
      idle(1'b1);
    end
    cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("clr_err", 32'(o_error), 32'd0);

    // Unexpected result, then clear (clear beats the concurrent issue and push).
    ret(16'h1234, 16'h0042, 1'b0);
    chk("unexp_err", 32'(o_error), 32'd2);
    cyc(1'b1, 1'b1, 1'b1, 16'd7, 16'd7, 1'b1);
    chk("clr2_err", 32'(o_error), 32'd0);
    chk("clr2_count", 32'(o_count), 32'd0);
    chk("clr2_valid", 32'(o_valid), 32'd0);
    chk("clr2_issue_ok", 32'(o_issue_ok), 32'd1);

    // Random run: 40 divisions, fixed 30-cycle divider latency, random backpressure.
    begin
      int issued, cnum, pops0;
      bit iss, dv;
      logic [DW-1:0] a, b, qq, rr;
      pend_t p;
      issued = 0; cnum = 0; pops0 = dut_pops;
      while ((issued < 40 || pend.size() != 0 || mq.size() != 0) && cnum < 5000) begin
        iss = (issued < 40) && ((mq.size() + m_infl) < DEPTH) && ($urandom_range(0, 3) != 0);
        if (iss) begin
          a = 16'($urandom_range(0, 65535));
          b = 16'($urandom_range(1, 65535));
          pend.push_back('{due: cnum + 30, q: a / b, r: a % b});
          issued++;
        end
        dv = 1'b0; qq = '0; rr = '0;
        if (pend.size() != 0 && pend[0].due == cnum) begin
          p = pend.pop_front();
          dv = 1'b1; qq = p.q; rr = p.r;
        end
        cyc(1'b0, iss, dv, qq, rr, 1'($urandom_range(0, 1)));
        cnum++;
      end
      chk("rand_timeout", 32'(cnum < 5000), 32'd1);
      chk("rand_pops", 32'(dut_pops - pops0), 32'd40);
      chk("rand_err", 32'(o_error), 32'd0);
      chk("rand_issue_ok", 32'(o_issue_ok), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
